sha256_digest_reader: RTL and testbench
=======================================

Name: sha256_digest_reader

Overview:
- Unload side of the SHA-256 datapath: captures the final 256-bit hash state (H0..H7) in one cycle when the core signals completion.
- Streams the state out as eight 32-bit words, H0 first, over a valid/ready handshake.
- Sits between the compression-round state registers and the host/output bus.
- Releases the core immediately after capture; the core may start the next message while the digest drains.

Parameters:
- WORD_W, 32, width of one output word.
- N_WORDS, 8, number of words per digest; DIGEST_W = WORD_W*N_WORDS.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset; RST=0 forces reset state immediately.
- load  input  1  one-cycle capture strobe from the core; only honoured in IDLE.
- digest_i  input  DIGEST_W  final hash state; H0 in [255:224], H7 in [31:0].
- out_ready  input  1  downstream can accept a word this cycle.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  WORD_W  current digest word.
- out_last  output  1  qualifies the word with out_valid; high only for H7.
- busy  output  1  high from the cycle after capture until the last word is accepted.
- done  output  1  one-cycle pulse the cycle after the final transfer.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; buffer, index, out_data all zero.
  - out_valid=0, out_last=0, busy=0, done=0.
  - Takes effect mid-stream too; a partial digest is discarded and no done pulse follows.
- States: IDLE, SEND.
- IDLE:
  - out_valid=0.
  - On load=1 at edge N: copy digest_i into the internal buffer, idx=0, go to SEND.
  - At N+1: out_valid=1, out_data=H0, busy=1.
  - Latency from load to first valid word: 1 cycle.
- SEND:
  - out_data = buffer word idx (idx=0 selects bits [255:224]).
  - Transfer occurs on an edge where out_valid && out_ready.
  - On transfer with idx<N_WORDS-1: idx increments, next word is presented the following cycle. No bubbles, so back-to-back ready gives one word per cycle.
  - out_last = (idx==N_WORDS-1) while out_valid.
  - On transfer with idx==N_WORDS-1: go to IDLE; out_valid=0, busy=0, done=1 for exactly one cycle after that edge.
- Stall: while out_valid=1 and out_ready=0, out_data, out_last and idx hold stable. Valid never drops without a transfer.
- Ready handling: out_ready may be high while out_valid=0 and is ignored then; out_valid does not depend on out_ready.
- load while in SEND: ignored; the buffer is not overwritten and the stream continues unchanged.
- load in the same cycle as the final transfer: ignored. The state is still SEND at that edge, so the core must re-issue load after done.
- Throughput: minimum 9 cycles per digest (1 capture + 8 transfers); the done cycle overlaps the next IDLE.
- Width rules:
  - idx is $clog2(N_WORDS) bits.
  - No byte reordering; words are emitted exactly as held in the state registers (big-endian per SHA-256).

Decomposition:
- Shared package sha256_pkg:
  - WORD_W=32, N_WORDS=8, DIGEST_W=256.
  - State enum {IDLE, SEND}.
  - SHA-256 initial H constants, shared with the core.
- No sub-module: the capture buffer, word mux and counter are small; keep the block flat in a single module.

Test Plan:
- Single digest, ready held high: load digest of "abc" (ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad).
  - Eight consecutive valid cycles in that order, starting 1 cycle after load.
  - out_last only on f20015ad; done pulses the following cycle; busy high for exactly 8 cycles.
- Backpressure: same digest, out_ready toggled 1,0,0,1,0,1...
  - Every word is emitted exactly once, in order.
  - out_data is stable across each stall; the total count of valid&&ready transfers is 8.
- Load during SEND: after 3 words are transferred, pulse load with digest_i=all 0xFFFFFFFF.
  - The remaining 5 words are still 5dae2223..f20015ad; no 0xFFFFFFFF word appears.
- Reset mid-stream: assert RST=0 asynchronously after word 4.
  - out_valid, busy and out_data drop to 0 immediately; no done pulse.
  - After release, a new load of 00000001..00000008 emits 1..8.
- Back-to-back digests: load the second digest on the cycle after done.
  - Second stream starts 1 cycle later.
  - A load coincident with the final transfer is ignored (no second stream).

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions used by the core and its digest unload path.
package sha256_pkg;

  localparam int WORD_W   = 32;
  localparam int N_WORDS  = 8;
  localparam int DIGEST_W = WORD_W * N_WORDS;

  // Unload FSM: waiting for a capture strobe, or draining captured words.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Initial hash state H0..H7, H0 in the most significant word.
  localparam logic [DIGEST_W-1:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

endpackage

// File: rtl/sha256_digest_reader.sv
// Captures the final SHA-256 hash state in one cycle and streams it out as
// N_WORDS words (H0 first) over a valid/ready handshake. The core is free to
// start its next message as soon as the capture edge has passed.
module sha256_digest_reader
  import sha256_pkg::state_t, sha256_pkg::IDLE, sha256_pkg::SEND;
#(
  parameter int WORD_W    = sha256_pkg::WORD_W,
  parameter int N_WORDS   = sha256_pkg::N_WORDS,
  localparam int DIGEST_W = WORD_W * N_WORDS
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                load,
  input  logic [DIGEST_W-1:0] digest_i,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  state_t state;
  state_t state_next;

  // Word 0 (H0) lives in the top slice, so buffer[N_WORDS-1] is H0.
  logic [N_WORDS-1:0][WORD_W-1:0] buffer;
  logic [IDX_W-1:0]               idx;
  logic [IDX_W-1:0]               word_sel;
  logic                           xfer;
  logic                           last_xfer;

  assign xfer      = (state == SEND) && out_ready;
  assign last_xfer = xfer && (idx == LAST_IDX);
  assign word_sel  = LAST_IDX - idx;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: capture only from IDLE, so a load during SEND (including the final transfer edge) is dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (load)      state_next = SEND;
      SEND: if (last_xfer) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Capture buffer, word index and the one-cycle completion pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      buffer <= '0;
      idx    <= '0;
      done   <= 1'b0;
    end else begin
      done <= last_xfer;
      if ((state == IDLE) && load) begin
        buffer <= digest_i;
        idx    <= '0;
      end else if (last_xfer) begin
        idx <= '0;
      end else if (xfer) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Outputs are decoded from the state alone so valid never depends on ready.
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    if (state == SEND) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_last  = (idx == LAST_IDX);
      out_data  = buffer[word_sel];
    end
  end

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Scoreboard bench for the SHA-256 digest unload path.
module tb_sha256_digest_reader;

  localparam logic [255:0] ABC  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] SEQ  = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
  localparam logic [255:0] ONES = {256{1'b1}};

  logic         CLK = 1'b0;
  logic         RST;
  logic         load;
  logic [255:0] digest_i;
  logic         out_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         done;

  logic [31:0] sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  sha256_digest_reader dut (
    .CLK       (CLK),
    .RST       (RST),
    .load      (load),
    .digest_i  (digest_i),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  // Expected words of a digest, H0 first.
  task automatic push_digest(input logic [255:0] d);
    for (int i = 0; i < 8; i++) sb.push_back(d[255 - 32*i -: 32]);
  endtask

  task automatic test_reset();
    RST = 1'b0; load = 1'b0; digest_i = '0; out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_last: got %b expected 0", out_last); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 00000000", out_data); end
    RST = 1'b1; out_ready = 1'b1;
    @(negedge CLK);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_ready_ignored: got valid %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_single();
    int xfers = 0, busy_cycles = 0;
    bit finished = 0;
    sb.delete();
    load = 1'b1; digest_i = ABC; out_ready = 1'b1; push_digest(ABC);
    for (int c = 0; c < 12 && !finished; c++) begin
      @(negedge CLK);
      load = 1'b0;
      if (busy) busy_cycles++;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid c%0d: got %b expected 1", c, out_valid); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_done c%0d: got %b expected 0", c, done); end
      if (out_valid && sb.size() > 0) begin
        n_checks++; if (out_data !== sb[0]) begin n_fail++; $display("[TB] FAIL single_data c%0d: got %h expected %h", c, out_data, sb[0]); end
        n_checks++; if (out_last !== (sb.size() == 1)) begin n_fail++; $display("[TB] FAIL single_last c%0d: got %b expected %b", c, out_last, sb.size() == 1); end
        void'(sb.pop_front()); xfers++;
        if (sb.size() == 0) finished = 1;
      end
    end
    n_checks++; if (!finished) begin n_fail++; $display("[TB] FAIL single_timeout: got %0d words expected 8", xfers); end
    @(negedge CLK);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL single_done: got %b expected 1", done); end
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_idle: got valid %b busy %b expected 0 0", out_valid, busy); end
    @(negedge CLK);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL single_done_width: got %b expected 0", done); end
    n_checks++; if (busy_cycles != 8) begin n_fail++; $display("[TB] FAIL single_busy_cycles: got %0d expected 8", busy_cycles); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int xfers = 0;
    bit stalled = 0;
    logic [31:0] prev = '0;
    sb.delete();
    load = 1'b1; digest_i = ABC; out_ready = 1'b0; push_digest(ABC);
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge CLK);
      load = 1'b0;
      out_ready = pat[c % 6];
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_valid c%0d: got %b expected 1", c, out_valid); end
      if (stalled) begin
        n_checks++; if (out_data !== prev) begin n_fail++; $display("[TB] FAIL bp_stall_stable c%0d: got %h expected %h", c, out_data, prev); end
      end
      n_checks++; if (out_data !== sb[0]) begin n_fail++; $display("[TB] FAIL bp_data c%0d: got %h expected %h", c, out_data, sb[0]); end
      n_checks++; if (out_last !== (sb.size() == 1)) begin n_fail++; $display("[TB] FAIL bp_last c%0d: got %b expected %b", c, out_last, sb.size() == 1); end
      prev = out_data;
      stalled = !out_ready;
      if (out_valid && out_ready) begin void'(sb.pop_front()); xfers++; end
    end
    n_checks++; if (xfers != 8) begin n_fail++; $display("[TB] FAIL bp_xfers: got %0d expected 8", xfers); end
    @(negedge CLK);
    out_ready = 1'b0;
    n_checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_done: got done %b valid %b expected 1 0", done, out_valid); end
  endtask

  task automatic test_load_during_send();
    int xfers = 0;
    sb.delete();
    load = 1'b1; digest_i = ABC; out_ready = 1'b1; push_digest(ABC);
    for (int c = 0; c < 14 && sb.size() > 0; c++) begin
      @(negedge CLK);
      load     = (xfers == 3);
      digest_i = (xfers == 3) ? ONES : ABC;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL lds_valid c%0d: got %b expected 1", c, out_valid); end
      n_checks++; if (out_data !== sb[0]) begin n_fail++; $display("[TB] FAIL lds_data c%0d: got %h expected %h", c, out_data, sb[0]); end
      void'(sb.pop_front()); xfers++;
    end
    @(negedge CLK);
    load = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL lds_done: got %b expected 1", done); end
    @(negedge CLK);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL lds_no_restart: got valid %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    int xfers = 0;
    sb.delete();
    load = 1'b1; digest_i = ABC; out_ready = 1'b1;
    while (xfers < 4) begin
      @(negedge CLK);
      load = 1'b0;
      xfers++;
    end
    #2 RST = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_async_flags: got valid %b busy %b expected 0 0", out_valid, busy); end
    n_checks++; if (out_data !== 32'h0 || out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_async_data: got %h last %b expected 00000000 0", out_data, out_last); end
    @(negedge CLK);
    RST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_no_done c%0d: got done %b valid %b expected 0 0", c, done, out_valid); end
    end
    load = 1'b1; digest_i = SEQ; push_digest(SEQ);
    for (int c = 0; c < 12 && sb.size() > 0; c++) begin
      @(negedge CLK);
      load = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_data !== sb[0]) begin n_fail++; $display("[TB] FAIL rst_reload c%0d: got valid %b data %h expected 1 %h", c, out_valid, out_data, sb[0]); end
      void'(sb.pop_front());
    end
    @(negedge CLK);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_reload_done: got %b expected 1", done); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    sb.delete();
    load = 1'b1; digest_i = ABC; out_ready = 1'b1; push_digest(ABC);
    for (int c = 0; c < 12 && sb.size() > 0; c++) begin
      @(negedge CLK);
      load = 1'b0;
      n_checks++; if (out_data !== sb[0]) begin n_fail++; $display("[TB] FAIL b2b_first_data c%0d: got %h expected %h", c, out_data, sb[0]); end
      void'(sb.pop_front());
    end
    @(negedge CLK);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_first_done: got %b expected 1", done); end
    load = 1'b1; digest_i = SEQ; push_digest(SEQ);
    for (int c = 0; c < 12 && sb.size() > 0; c++) begin
      @(negedge CLK);
      load = (sb.size() == 1);
      digest_i = (sb.size() == 1) ? ABC : SEQ;
      n_checks++; if (out_valid !== 1'b1 || out_data !== sb[0]) begin n_fail++; $display("[TB] FAIL b2b_second c%0d: got valid %b data %h expected 1 %h", c, out_valid, out_data, sb[0]); end
      void'(sb.pop_front());
    end
    @(negedge CLK);
    load = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_second_done: got %b expected 1", done); end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_final_load_ignored c%0d: got valid %b busy %b expected 0 0", c, out_valid, busy); end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_load_during_send();
    test_reset_mid_stream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
